// File: rtl/spi_slave_regfile.sv
// SPI slave with a small register file: 7 R/W byte registers plus a
// read-only ID at address 7. Frames are LSB-first. The first byte is a
// command; the bytes after it are data for a write or are ignored for a read.
// Read data is presented for the shifter to load at the start of the next frame.
module spi_slave_regfile #(
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic        reset,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic [7:0]  slaveDataToSend,
    output logic [63:0] regs_out,
    output logic [7:0]  wr_count,
    output logic [2:0]  rd_ptr
);

    // Byte position within the frame; saturates once the data phase is reached.
    typedef enum logic [1:0] {
        PH_CMD   = 2'd0,
        PH_DATA1 = 2'd1,
        PH_DATA2 = 2'd2
    } phase_t;

    // Frame state: cleared whenever CS is high.
    phase_t      phase_q, phase_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  waddr_q, waddr_d;
    logic        wmode_q, wmode_d;

    // Persistent state: survives frame boundaries.
    logic [6:0][7:0] regs_q, regs_d;
    logic [2:0]      rd_ptr_q, rd_ptr_d;
    logic [7:0]      wr_count_q, wr_count_d;

    logic [7:0] byte_w;
    logic       commit;

    // Next-state logic: shift one bit, and on the 8th bit act on the byte.
    always_comb begin
        byte_w     = {MOSI, shreg_q[7:1]};
        commit     = (bitcnt_q == 3'd7);
        bitcnt_d   = bitcnt_q + 3'd1;      // 7 wraps to 0 naturally
        shreg_d    = byte_w;
        phase_d    = phase_q;
        waddr_d    = waddr_q;
        wmode_d    = wmode_q;
        regs_d     = regs_q;
        rd_ptr_d   = rd_ptr_q;
        wr_count_d = wr_count_q;
        if (commit) begin
            phase_d = (phase_q == PH_CMD) ? PH_DATA1 : PH_DATA2;
            if (phase_q == PH_CMD) begin
                wmode_d = byte_w[7];
                if (byte_w[7]) waddr_d  = byte_w[2:0];
                else           rd_ptr_d = byte_w[2:0];
            end else if (wmode_q) begin
                // Address 7 is read-only: drop the byte but still step the address.
                if (waddr_q != 3'd7) begin
                    regs_d[waddr_q] = byte_w;
                    wr_count_d      = wr_count_q + 8'd1;
                end
                waddr_d = waddr_q + 3'd1;
            end
        end
    end

    // Frame state register; CS high holds it cleared so a partial byte is lost.
    always_ff @(negedge SCLK or posedge reset or posedge CS) begin
        if (reset || CS) begin
            phase_q  <= PH_CMD;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'h00;
            waddr_q  <= 3'd0;
            wmode_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            waddr_q  <= waddr_d;
            wmode_q  <= wmode_d;
        end
    end

    // Register file and pointers. No CS gate needed: with CS high the bit
    // counter is held at 0, so no commit can happen.
    always_ff @(negedge SCLK or posedge reset) begin
        if (reset) begin
            regs_q     <= '0;
            rd_ptr_q   <= 3'd0;
            wr_count_q <= 8'd0;
        end else begin
            regs_q     <= regs_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_count_q <= wr_count_d;
        end
    end

    // The ID is not part of the flat image, which keeps that byte at zero.
    assign regs_out        = {8'h00, regs_q};
    assign slaveDataToSend = (rd_ptr_q == 3'd7) ? ID_VALUE : regs_q[rd_ptr_q];
    assign wr_count        = wr_count_q;
    assign rd_ptr          = rd_ptr_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: directed scenarios followed by random frames,
// all checked against a byte-level model of the register file.
module tb_spi_slave_regfile;

    localparam logic [7:0] ID = 8'hA5;

    logic        reset = 1'b1;
    logic        SCLK  = 1'b0;
    logic        CS    = 1'b1;
    logic        MOSI  = 1'b0;
    logic [7:0]  sd;
    logic [63:0] ro;
    logic [7:0]  wc;
    logic [2:0]  rp;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0] m_regs [7];
    logic [2:0] m_rd;
    logic [7:0] m_wc;

    logic [7:0]  fb [4];
    logic [63:0] saved_img;
    logic [7:0]  saved_wc;

    spi_slave_regfile #(.ID_VALUE(ID)) dut (
        .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .slaveDataToSend(sd), .regs_out(ro), .wr_count(wc), .rd_ptr(rp)
    );

    always #5 SCLK = ~SCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_image();
        logic [63:0] img = '0;
        for (int k = 0; k < 7; k++) img[8*k +: 8] = m_regs[k];
        return img;
    endfunction

    function automatic logic [7:0] m_sd();
        return (m_rd == 3'd7) ? ID : m_regs[m_rd];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 7; k++) m_regs[k] = 8'h00;
        m_rd = 3'd0;
        m_wc = 8'd0;
    endtask

    // Only whole bytes matter; a trailing partial byte has no effect.
    task automatic m_frame(input int nbits);
        int         nfull = nbits / 8;
        logic       wr = 1'b0;
        logic [2:0] wa = 3'd0;
        logic [7:0] b;
        for (int i = 0; i < nfull; i++) begin
            b = fb[i];
            if (i == 0) begin
                wr = b[7];
                if (wr) wa = b[2:0];
                else    m_rd = b[2:0];
            end else if (wr) begin
                if (wa != 3'd7) begin
                    m_regs[wa] = b;
                    m_wc = m_wc + 8'd1;
                end
                wa = wa + 3'd1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".img"}, ro, m_image());
        check({tag, ".rd"},  {61'd0, rp}, {61'd0, m_rd});
        check({tag, ".wc"},  {56'd0, wc}, {56'd0, m_wc});
        check({tag, ".sd"},  {56'd0, sd}, {56'd0, m_sd()});
    endtask

    // Drive nbits of fb (LSB first). MOSI/CS change on rising edges; the DUT
    // samples on falling edges. The image is checked before CS rises so a
    // commit must be visible right after the 8th falling edge.
    task automatic spi_frame(input int nbits);
        logic [7:0] b;
        if (nbits == 0) begin
            @(negedge SCLK);
            #1 CS = 1'b0;
            #3 CS = 1'b1;
            @(posedge SCLK);
            return;
        end
        @(posedge SCLK);
        CS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            b = fb[i / 8];
            MOSI = b[i % 8];
            @(posedge SCLK);
        end
        m_frame(nbits);
        check("live_img", ro, m_image());
        CS = 1'b1;
        @(posedge SCLK);
    endtask

    initial begin
        logic [7:0] b;
        m_reset();
        repeat (3) @(posedge SCLK);
        check_all("reset");
        check("reset.ro0", ro, 64'h0);
        check("reset.sd0", {56'd0, sd}, 64'h0);
        reset = 1'b0;
        @(posedge SCLK);

        // Write then read back.
        fb = '{8'h83, 8'h5A, 8'h00, 8'h00};
        spi_frame(16);
        check_all("wr");
        check("wr.reg3", {56'd0, ro[31:24]}, 64'h5A);
        check("wr.wc", {56'd0, wc}, 64'd1);
        fb = '{8'h03, 8'h00, 8'h00, 8'h00};
        spi_frame(8);
        check("rd.sd", {56'd0, sd}, 64'h5A);

        // Address wrap across the read-only ID.
        fb = '{8'h86, 8'h11, 8'h22, 8'h33};
        spi_frame(32);
        check_all("wrap");
        check("wrap.reg6", {56'd0, ro[55:48]}, 64'h11);
        check("wrap.reg0", {56'd0, ro[7:0]}, 64'h33);
        check("wrap.top",  {56'd0, ro[63:56]}, 64'h0);
        check("wrap.wc",   {56'd0, wc}, 64'd3);

        // ID read; data bytes in a read frame are ignored.
        fb = '{8'h07, 8'h00, 8'h00, 8'h00};
        spi_frame(8);
        check("id.sd", {56'd0, sd}, {56'd0, ID});
        saved_img = ro;
        fb = '{8'h07, 8'hFF, 8'h00, 8'h00};
        spi_frame(16);
        check("rdframe.img", ro, saved_img);
        check_all("rdframe");

        // Abort mid data byte, then a clean write.
        saved_wc = wc;
        fb = '{8'h81, 8'h77, 8'h00, 8'h00};
        spi_frame(13);
        check("abort.reg1", {56'd0, ro[15:8]}, 64'h0);
        check("abort.wc", {56'd0, wc}, {56'd0, saved_wc});
        fb = '{8'h81, 8'h44, 8'h00, 8'h00};
        spi_frame(16);
        check("abort.reg1b", {56'd0, ro[15:8]}, 64'h44);
        check_all("abort");

        // Zero-edge frame.
        spi_frame(0);
        check_all("zero");

        // Reset in the middle of the data byte of {0x82, 0x99}, CS held low,
        // then the following byte must act as a fresh command (read addr 1).
        @(posedge SCLK);
        CS = 1'b0;
        for (int i = 0; i < 12; i++) begin
            b = (i < 8) ? 8'h82 : 8'h99;
            MOSI = b[i % 8];
            @(posedge SCLK);
        end
        reset = 1'b1;
        m_reset();
        #2;
        check_all("rst_mid");
        @(posedge SCLK);
        reset = 1'b0;
        b = 8'h01;
        for (int i = 0; i < 8; i++) begin
            MOSI = b[i];
            @(posedge SCLK);
        end
        m_rd = 3'd1;
        CS = 1'b1;
        @(posedge SCLK);
        check_all("rst_after");
        check("rst.reg2", {56'd0, ro[23:16]}, 64'h0);
        check("rst.rd", {61'd0, rp}, 64'd1);

        // Random frames.
        for (int t = 0; t < 80; t++) begin
            int nb;
            for (int k = 0; k < 4; k++) fb[k] = 8'($urandom);
            nb = $urandom_range(0, 32);
            spi_frame(nb);
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
